// File: rtl/divider_multicycle_pkg.sv
// Shared definitions for the multicycle restoring divider.
package divider_multicycle_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/divider_multicycle_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             num_bit,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;

    assign shifted = {rem_in, num_bit};
    assign q_bit   = (shifted >= {2'b00, divisor});
    // The restored or reduced remainder always fits back into WIDTH+1 bits.
    assign rem_out = (WIDTH+1)'(q_bit ? (shifted - {2'b00, divisor}) : shifted);

endmodule

// File: rtl/divider_multicycle.sv
// Iterative restoring divider with signed/unsigned mode, RISC-V special cases and a
// pass-through tag; BITS_PER_CYCLE chained steps resolve quotient bits each cycle.
module divider_multicycle
    import divider_multicycle_pkg::*;
#(
    parameter int DIV_SIZE       = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_WIDTH      = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_i,
    input  logic [DIV_SIZE-1:0]  numerator,
    input  logic [DIV_SIZE-1:0]  denominator,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 ready_o,
    output logic [DIV_SIZE-1:0]  quotient,
    output logic [DIV_SIZE-1:0]  remainder,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic                 valid,
    input  logic                 ready_i
);

    localparam int N     = DIV_SIZE / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [DIV_SIZE-1:0] ALL_ONES   = '1;
    localparam logic [DIV_SIZE-1:0] SIGNED_MIN = {1'b1, {(DIV_SIZE-1){1'b0}}};

    div_state_e state, next_state;

    logic [DIV_SIZE-1:0]       num_reg;
    logic [DIV_SIZE-1:0]       den_reg;
    logic [DIV_SIZE:0]         rem_reg;
    logic                      signed_reg;
    logic                      q_neg;
    logic                      r_neg;
    logic [CNT_W-1:0]          count;
    logic [TAG_WIDTH-1:0]      tag_reg;

    logic                      den_zero;
    logic                      ovf_case;
    logic                      num_neg;
    logic                      den_neg;
    logic [DIV_SIZE:0]         rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [DIV_SIZE-1:0]       num_next;

    assign den_zero = (den_reg == '0);
    assign ovf_case = signed_reg && (num_reg == SIGNED_MIN) && (den_reg == ALL_ONES);
    assign num_neg  = signed_reg & num_reg[DIV_SIZE-1];
    assign den_neg  = signed_reg & den_reg[DIV_SIZE-1];

    // num_reg doubles as the quotient: dividend bits shift out the top while
    // resolved quotient bits shift in at the bottom.
    assign rem_chain[0] = rem_reg;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.WIDTH(DIV_SIZE)) u_step (
            .rem_in  (rem_chain[i]),
            .divisor (den_reg),
            .num_bit (num_reg[DIV_SIZE-1-i]),
            .rem_out (rem_chain[i+1]),
            .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
        );
    end
    assign num_next = (num_reg << BITS_PER_CYCLE) | DIV_SIZE'(q_bits);

    assign ready_o = (state == IDLE);
    assign valid   = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = PREP;
            PREP: next_state = (den_zero || ovf_case) ? DONE : ITER;
            ITER: if (count == '0) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: if (ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Special cases resolve straight from PREP; regular results are sign-fixed in FIX.
    always_ff @(posedge clock) begin
        if (reset) begin
            num_reg     <= '0;
            den_reg     <= '0;
            rem_reg     <= '0;
            signed_reg  <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            count       <= '0;
            tag_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            tag_o       <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_reg     <= numerator;
                        den_reg     <= denominator;
                        signed_reg  <= signed_i;
                        tag_reg     <= tag_i;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                PREP: begin
                    if (den_zero) begin
                        quotient    <= ALL_ONES;
                        remainder   <= num_reg;
                        div_by_zero <= 1'b1;
                        tag_o       <= tag_reg;
                    end else if (ovf_case) begin
                        quotient    <= SIGNED_MIN;
                        remainder   <= '0;
                        overflow    <= 1'b1;
                        tag_o       <= tag_reg;
                    end else begin
                        num_reg <= num_neg ? -num_reg : num_reg;
                        den_reg <= den_neg ? -den_reg : den_reg;
                        q_neg   <= num_neg ^ den_neg;
                        r_neg   <= num_neg;
                        rem_reg <= '0;
                        count   <= CNT_W'(N - 1);
                    end
                end
                ITER: begin
                    num_reg <= num_next;
                    rem_reg <= rem_chain[BITS_PER_CYCLE];
                    count   <= count - CNT_W'(1);
                end
                FIX: begin
                    quotient  <= q_neg ? -num_reg : num_reg;
                    remainder <= r_neg ? -rem_reg[DIV_SIZE-1:0] : rem_reg[DIV_SIZE-1:0];
                    tag_o     <= tag_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_multicycle.sv
// Directed bench for divider_multicycle: DIV_SIZE=8, one instance at 1 and one at 2 bits/cycle.
module tb_divider_multicycle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic       signed_i = 1'b0;
    logic [7:0] numerator = '0, denominator = '0;
    logic [4:0] tag_i = '0;
    logic       ready_i = 1'b0;

    logic       ready1, valid1, dbz1, ovf1;
    logic [7:0] q1, r1;
    logic [4:0] tag1;
    logic       ready2, valid2, dbz2, ovf2;
    logic [7:0] q2, r2;
    logic [4:0] tag2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    divider_multicycle #(.DIV_SIZE(8), .BITS_PER_CYCLE(1), .TAG_WIDTH(5)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .signed_i(signed_i),
        .numerator(numerator), .denominator(denominator), .tag_i(tag_i),
        .ready_o(ready1), .quotient(q1), .remainder(r1), .tag_o(tag1),
        .div_by_zero(dbz1), .overflow(ovf1), .valid(valid1), .ready_i(ready_i)
    );

    divider_multicycle #(.DIV_SIZE(8), .BITS_PER_CYCLE(2), .TAG_WIDTH(5)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .signed_i(signed_i),
        .numerator(numerator), .denominator(denominator), .tag_i(tag_i),
        .ready_o(ready2), .quotient(q2), .remainder(r2), .tag_o(tag2),
        .div_by_zero(dbz2), .overflow(ovf2), .valid(valid2), .ready_i(ready_i)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request, wait (bounded) for valid, capture the result, then retire it.
    task automatic run_op(input bit which, input bit sgn, input logic [7:0] n, input logic [7:0] d,
                          input logic [4:0] tg, output logic [7:0] q, output logic [7:0] r,
                          output logic [4:0] tgo, output logic dz, output logic ov, output int lat);
        signed_i = sgn; numerator = n; denominator = d; tag_i = tg;
        if (which) start2 = 1'b1; else start1 = 1'b1;
        step();
        start1 = 1'b0; start2 = 1'b0;
        lat = 0;
        while (!(which ? valid2 : valid1) && lat < 40) begin
            step();
            lat++;
        end
        q   = which ? q2 : q1;
        r   = which ? r2 : r1;
        tgo = which ? tag2 : tag1;
        dz  = which ? dbz2 : dbz1;
        ov  = which ? ovf2 : ovf1;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({ready1, valid1, dbz1, ovf1, q1, r1, tag1} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00}) begin
            errors++;
            $display("[TB] FAIL reset_state: rdy=%b vld=%b dz=%b ov=%b q=%h r=%h tag=%h, want 1 0 0 0 00 00 00",
                     ready1, valid1, dbz1, ovf1, q1, r1, tag1);
        end
        checks++;
        if ({ready2, valid2} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_state_bpc2: rdy=%b vld=%b, want 1 0", ready2, valid2);
        end
    endtask

    task automatic test_unsigned();
        logic [7:0] q, r; logic [4:0] tg; logic dz, ov; int lat;
        run_op(1'b0, 1'b0, 8'd200, 8'd7, 5'h13, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r, tg, dz, ov} !== {8'd28, 8'd4, 5'h13, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL unsigned_200_7: q=%0d r=%0d tag=%h dz=%b ov=%b, want 28 4 13 0 0", q, r, tg, dz, ov);
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("[TB] FAIL unsigned_latency: got %0d edges, want 10", lat);
        end
        checks++;
        if ({ready1, valid1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL release_to_idle: rdy=%b vld=%b, want 1 0", ready1, valid1);
        end
        checks++;
        if (q1 !== 8'd28) begin
            errors++;
            $display("[TB] FAIL hold_after_idle: q=%0d, want 28", q1);
        end
    endtask

    task automatic test_signed();
        logic [7:0] q, r; logic [4:0] tg; logic dz, ov; int lat;
        run_op(1'b0, 1'b1, 8'hF9, 8'h02, 5'h01, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r, lat} !== {8'hFD, 8'hFF, 32'd10}) begin
            errors++;
            $display("[TB] FAIL signed_m7_2: q=%h r=%h lat=%0d, want FD FF 10", q, r, lat);
        end
        run_op(1'b0, 1'b1, 8'h07, 8'hFE, 5'h02, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r} !== {8'hFD, 8'h01}) begin
            errors++;
            $display("[TB] FAIL signed_7_m2: q=%h r=%h, want FD 01", q, r);
        end
        run_op(1'b0, 1'b1, 8'hF9, 8'hFE, 5'h03, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r} !== {8'h03, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL signed_m7_m2: q=%h r=%h, want 03 FF", q, r);
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic [4:0] tg; logic dz, ov; int lat;
        run_op(1'b0, 1'b0, 8'h01, 8'h00, 5'h0A, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r, tg, dz, ov, lat} !== {8'hFF, 8'h01, 5'h0A, 1'b1, 1'b0, 32'd1}) begin
            errors++;
            $display("[TB] FAIL divzero_unsigned: q=%h r=%h tag=%h dz=%b ov=%b lat=%0d, want FF 01 0A 1 0 1",
                     q, r, tg, dz, ov, lat);
        end
        run_op(1'b0, 1'b1, 8'hFB, 8'h00, 5'h0B, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r, dz, lat} !== {8'hFF, 8'hFB, 1'b1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL divzero_signed: q=%h r=%h dz=%b lat=%0d, want FF FB 1 1", q, r, dz, lat);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q, r; logic [4:0] tg; logic dz, ov; int lat;
        run_op(1'b0, 1'b1, 8'h80, 8'hFF, 5'h0C, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r, dz, ov, lat} !== {8'h80, 8'h00, 1'b0, 1'b1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL overflow_signed: q=%h r=%h dz=%b ov=%b lat=%0d, want 80 00 0 1 1", q, r, dz, ov, lat);
        end
        run_op(1'b0, 1'b0, 8'h80, 8'hFF, 5'h0D, q, r, tg, dz, ov, lat);
        checks++;
        if ({q, r, dz, ov, lat} !== {8'h00, 8'h80, 1'b0, 1'b0, 32'd10}) begin
            errors++;
            $display("[TB] FAIL overflow_unsigned: q=%h r=%h dz=%b ov=%b lat=%0d, want 00 80 0 0 10", q, r, dz, ov, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        signed_i = 1'b0; numerator = 8'd100; denominator = 8'd9; tag_i = 5'h07;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        lat = 0;
        while (!valid1 && lat < 40) begin
            step();
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                numerator = 8'd3; denominator = 8'd1; tag_i = 5'h1F; start1 = 1'b1;
            end
            step();
            start1 = 1'b0;
            checks++;
            if ({valid1, ready1, q1, r1, tag1} !== {1'b1, 1'b0, 8'd11, 8'd1, 5'h07}) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: vld=%b rdy=%b q=%0d r=%0d tag=%h, want 1 0 11 1 07",
                         k, valid1, ready1, q1, r1, tag1);
            end
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checks++;
        if ({valid1, ready1} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL backpressure_release: vld=%b rdy=%b, want 0 1", valid1, ready1);
        end
        step(); step();
        checks++;
        if ({valid1, ready1, q1, tag1} !== {1'b0, 1'b1, 8'd11, 5'h07}) begin
            errors++;
            $display("[TB] FAIL start_not_queued: vld=%b rdy=%b q=%0d tag=%h, want 0 1 11 07", valid1, ready1, q1, tag1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, gap;
        signed_i = 1'b0; numerator = 8'd50; denominator = 8'd6; tag_i = 5'h05;
        ready_i = 1'b1;
        start1 = 1'b1;
        cyc = 0;
        while (!valid1 && cyc < 40) begin
            step();
            cyc++;
        end
        checks++;
        if ({valid1, q1, r1} !== {1'b1, 8'd8, 8'd2}) begin
            errors++;
            $display("[TB] FAIL b2b_first: vld=%b q=%0d r=%0d, want 1 8 2", valid1, q1, r1);
        end
        step();
        checks++;
        if ({valid1, ready1} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_gap_idle: vld=%b rdy=%b, want 0 1", valid1, ready1);
        end
        step();
        start1 = 1'b0;
        checks++;
        if (ready1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: rdy=%b, want 0", ready1);
        end
        gap = 2;
        while (!valid1 && gap < 40) begin
            step();
            gap++;
        end
        checks++;
        if (gap !== 12) begin
            errors++;
            $display("[TB] FAIL b2b_period: got %0d edges between results, want 12", gap);
        end
        step();
        ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        signed_i = 1'b0; numerator = 8'd200; denominator = 8'd7; tag_i = 5'h11;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({ready1, valid1, q1} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_mid_iter: rdy=%b vld=%b q=%h, want 1 0 00", ready1, valid1, q1);
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (valid1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_result: valid rose after abort, want none");
        end
    endtask

    function automatic void ref_div(input bit sgn, input logic [7:0] n, input logic [7:0] d,
                                    output logic [7:0] q, output logic [7:0] r, output bit dz, output bit ov);
        int sn, sd;
        dz = 1'b0; ov = 1'b0;
        if (d == 8'h00) begin
            q = 8'hFF; r = n; dz = 1'b1;
        end else if (sgn && n == 8'h80 && d == 8'hFF) begin
            q = 8'h80; r = 8'h00; ov = 1'b1;
        end else if (sgn) begin
            sn = int'($signed(n));
            sd = int'($signed(d));
            q = 8'(sn / sd);
            r = 8'(sn % sd);
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    task automatic test_sweep_bpc2();
        logic [7:0] vals [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h10, 8'h3F,
                                  8'h7F, 8'h80, 8'h81, 8'hA5, 8'hC0, 8'hF9, 8'hFE, 8'hFF};
        logic [7:0] q, r, eq, er; logic [4:0] tg; logic dz, ov; bit edz, eov; int lat, elat;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    ref_div(s[0], vals[i], vals[j], eq, er, edz, eov);
                    elat = (edz || eov) ? 1 : 6;
                    run_op(1'b1, s[0], vals[i], vals[j], 5'(i + j), q, r, tg, dz, ov, lat);
                    checks++;
                    if ({q, r, tg, dz, ov, lat} !== {eq, er, 5'(i + j), edz, eov, elat}) begin
                        errors++;
                        $display("[TB] FAIL sweep s=%0d %h/%h: q=%h r=%h tag=%h dz=%b ov=%b lat=%0d, want %h %h %h %b %b %0d",
                                 s, vals[i], vals[j], q, r, tg, dz, ov, lat, eq, er, 5'(i + j), edz, eov, elat);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sweep_bpc2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
